// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller slice.
// Holds the ALU opcode encodings, the sequencer state encoding,
// instruction field positions and default widths.
package alu_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_NREGS  = 8;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned INSTR_W    = 9;

  // Instruction field positions: [8:6] op, [5:3] rd / source A, [2:0] rs / source B
  localparam int unsigned OP_MSB = 8;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RD_MSB = 5;
  localparam int unsigned RD_LSB = 3;
  localparam int unsigned RS_MSB = 2;
  localparam int unsigned RS_LSB = 0;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SHL = 3'b101,
    SHR = 3'b110,
    CMP = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction issue handshake between an instruction source and the
// sequencer.
//   instr_valid : source offers an instruction
//   instr_ready : sequencer can accept this cycle
//   instr       : [8:6] op, [5:3] rd, [2:0] rs
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );

endinterface

// File: rtl/reg_file.sv
// Register file for the issue controller: NREGS x DATA_W storage.
//   clk, reset          : clock, synchronous active-high clear to zero
//   rd_addr_a/rd_data_a : combinational operand read port A
//   rd_addr_b/rd_data_b : combinational operand read port B
//   host_addr/host_rdata: combinational host inspection port
//   we, waddr, wdata    : single synchronous write port
module reg_file
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  input  logic [REG_ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0]     host_rdata,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd_data_a  = regs[rd_addr_a];
  assign rd_data_b  = regs[rd_addr_b];
  assign host_rdata = regs[host_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle sequencer driving an external 8-bit ALU.
// Accepts one instruction per 4 cycles (IDLE->READ->EXEC->WB), reads the
// operands from its register file, registers them onto the ALU inputs,
// samples the ALU result/zero flag at the end of EXEC and writes back in WB
// (cmp only updates flag_z). A host port loads registers while idle.
//   clk, reset             : clock, synchronous active-high reset
//   instr_bus (slave)      : instr_valid / instr_ready / instr handshake
//   alu_op, alu_a, alu_b   : registered ALU operands
//   alu_result, alu_zero   : combinational ALU response
//   done                   : high for the writeback cycle
//   flag_z                 : zero flag of the last executed instruction
//   host_we/addr/wdata     : host register write, honoured in IDLE only
//   host_rdata             : combinational read of reg[host_addr]
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_issue_ctrl_if.slave       instr_bus,
  output logic [2:0]            alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  output logic                  done,
  output logic                  flag_z,
  input  logic                  host_we,
  input  logic [REG_ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic [DATA_W-1:0]     host_rdata
);

  state_t                state_q, state_n;
  alu_op_t               op_q;
  logic [REG_ADDR_W-1:0] rd_q, rs_q;
  alu_op_t               alu_op_q;
  logic [DATA_W-1:0]     alu_a_q, alu_b_q;
  logic [DATA_W-1:0]     result_q;
  logic                  flag_z_q;

  logic                  accept;
  logic                  wb_we, host_ok;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic [DATA_W-1:0]     rd_data_a, rd_data_b;

  assign instr_bus.instr_ready = (state_q == IDLE) && !reset;
  assign accept = instr_bus.instr_valid && instr_bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_n = READ;
      READ: state_n = EXEC;
      EXEC: state_n = WB;
      WB: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= ADD;
      rd_q     <= '0;
      rs_q     <= '0;
      alu_op_q <= ADD;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= alu_op_t'(instr_bus.instr[OP_MSB:OP_LSB]);
        rd_q <= instr_bus.instr[RD_MSB:RD_LSB];
        rs_q <= instr_bus.instr[RS_MSB:RS_LSB];
      end
      if (state_q == READ) begin
        alu_op_q <= op_q;
        alu_a_q  <= rd_data_a;
        alu_b_q  <= rd_data_b;
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        flag_z_q <= alu_zero;
      end
    end
  end

  // Single write port: writeback and host writes can never coincide, since
  // host writes are only taken in IDLE and writeback only happens in WB.
  always_comb begin
    wb_we    = (state_q == WB) && (op_q != CMP);
    host_ok  = (state_q == IDLE) && host_we && !accept;
    rf_we    = wb_we || host_ok;
    rf_waddr = host_addr;
    rf_wdata = host_wdata;
    if (wb_we) begin
      rf_waddr = rd_q;
      rf_wdata = result_q;
    end
  end

  reg_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_reg_file (
    .clk        (clk),
    .reset      (reset),
    .rd_addr_a  (rd_q),
    .rd_data_a  (rd_data_a),
    .rd_addr_b  (rs_q),
    .rd_data_b  (rd_data_b),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .we         (rf_we),
    .waddr      (rf_waddr),
    .wdata      (rf_wdata)
  );

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign flag_z = flag_z_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU alongside it.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_zero;
  logic       done, flag_z;
  logic       host_we;
  logic [2:0] host_addr;
  logic [7:0] host_wdata, host_rdata;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_ctrl_if ib ();

  alu_issue_ctrl #(
    .DATA_W (8),
    .NREGS  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_bus  (ib),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .done       (done),
    .flag_z     (flag_z),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  // Stand-in ALU; cmp returns 1 when the operands are equal.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = alu_a << 1;
      3'b110: alu_result = alu_a >> 1;
      default: alu_result = (alu_a == alu_b) ? 8'd1 : 8'd0;
    endcase
    alu_zero = (alu_result == 8'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    host_addr = a;
    #1;
    check(tag, host_rdata, exp);
  endtask

  // Issues one instruction and follows it to completion. hk selects the
  // post-accept cycle (0=READ,1=EXEC,2=WB) carrying a host write, -1 none;
  // acc_host puts a host write in the accept cycle itself.
  task automatic run_instr(input logic [8:0] ins, input int hk, input logic acc_host,
                           input logic [2:0] ha, input logic [7:0] hd);
    int guard;
    int done_at;
    @(negedge clk);
    ib.instr_valid = 1'b1;
    ib.instr       = ins;
    guard = 0;
    while (!ib.instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_at_accept", ib.instr_ready, 1'b1);
    host_we    = acc_host;
    host_addr  = ha;
    host_wdata = hd;
    @(negedge clk);
    ib.instr_valid = 1'b0;
    done_at = -1;
    for (int k = 0; k < 4; k++) begin
      host_we    = (k == hk);
      host_addr  = ha;
      host_wdata = hd;
      if (k < 3) check("ready_low_busy", ib.instr_ready, 1'b0);
      if (done && done_at < 0) done_at = k;
      if (k == 3) begin
        check("ready_after_wb", ib.instr_ready, 1'b1);
        check("done_cleared", done, 1'b0);
      end
      @(negedge clk);
    end
    host_we = 1'b0;
    check("done_latency", done_at, 2);
  endtask

  initial begin
    int accepts;
    int dones;
    int last_acc;

    reset          = 1'b1;
    ib.instr_valid = 1'b1;
    ib.instr       = 9'b000_001_010;
    host_we        = 1'b0;
    host_addr      = '0;
    host_wdata     = '0;

    // Reset held two cycles with an instruction offered
    @(negedge clk);
    check("rst_ready_c1", ib.instr_ready, 1'b0);
    @(negedge clk);
    check("rst_ready_c2", ib.instr_ready, 1'b0);
    reset          = 1'b0;
    ib.instr_valid = 1'b0;
    #1;
    check("rst_ready_after", ib.instr_ready, 1'b1);
    check("rst_flag_z", flag_z, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_alu_op", alu_op, 3'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 8'h00);

    // add r1,r2 with wrap: 200 + 100 = 300 mod 256 = 44
    host_write(3'd1, 8'd200);
    host_write(3'd2, 8'd100);
    run_instr(9'b000_001_010, -1, 1'b0, 3'd0, 8'h00);
    check_reg("add_r1", 3'd1, 8'd44);
    check_reg("add_r2", 3'd2, 8'd100);
    check("add_flag_z", flag_z, 1'b0);

    // sub to zero, then xor with self
    host_write(3'd3, 8'h5A);
    host_write(3'd4, 8'h5A);
    run_instr(9'b001_011_100, -1, 1'b0, 3'd0, 8'h00);
    check_reg("sub_r3", 3'd3, 8'h00);
    check("sub_flag_z", flag_z, 1'b1);
    run_instr(9'b100_100_100, -1, 1'b0, 3'd0, 8'h00);
    check_reg("xor_r4", 3'd4, 8'h00);
    check("xor_flag_z", flag_z, 1'b1);

    // cmp writes nothing; shifts ignore rs
    host_write(3'd5, 8'h81);
    host_write(3'd6, 8'h81);
    run_instr(9'b111_101_110, -1, 1'b0, 3'd0, 8'h00);
    check_reg("cmp_r5", 3'd5, 8'h81);
    check_reg("cmp_r6", 3'd6, 8'h81);
    check("cmp_flag_z", flag_z, 1'b0);
    run_instr(9'b101_101_000, -1, 1'b0, 3'd0, 8'h00);
    check_reg("shl_r5", 3'd5, 8'h02);
    run_instr(9'b110_110_000, -1, 1'b0, 3'd0, 8'h00);
    check_reg("shr_r6", 3'd6, 8'h40);
    check("shr_flag_z", flag_z, 1'b0);

    // Host write during EXEC is ignored (or r1,r1 keeps r1 = 44)
    run_instr(9'b011_001_001, 1, 1'b0, 3'd0, 8'hAA);
    check_reg("exec_host_r0", 3'd0, 8'h00);
    check_reg("or_r1", 3'd1, 8'd44);

    // Host write coinciding with an accept is dropped (and r3,r3 on r3 = 0)
    run_instr(9'b010_011_011, -1, 1'b1, 3'd2, 8'h77);
    check_reg("acc_host_r2", 3'd2, 8'd100);
    check("and_flag_z", flag_z, 1'b1);

    // Back-to-back: add r7,r7 held valid for 16 cycles doubles r7 four times
    host_write(3'd7, 8'd1);
    @(negedge clk);
    ib.instr_valid = 1'b1;
    ib.instr       = 9'b000_111_111;
    accepts  = 0;
    dones    = 0;
    last_acc = -1;
    for (int i = 0; i < 16; i++) begin
      if (ib.instr_ready) begin
        accepts++;
        last_acc = i;
      end
      if (done) dones++;
      @(negedge clk);
    end
    ib.instr_valid = 1'b0;
    check("b2b_accepts", accepts, 4);
    check("b2b_last_accept", last_acc, 12);
    check("b2b_dones", dones, 4);
    check_reg("b2b_r7", 3'd7, 8'd16);

    // Reset during EXEC: no writeback, registers cleared
    @(negedge clk);
    ib.instr_valid = 1'b1;
    ib.instr       = 9'b000_001_010;
    check("mid_ready", ib.instr_ready, 1'b1);
    @(negedge clk);
    ib.instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_done_rst", done, 1'b0);
    check("mid_ready_rst", ib.instr_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_done_after", done, 1'b0);
    check("mid_ready_after", ib.instr_ready, 1'b1);
    check("mid_flag_z", flag_z, 1'b0);
    check_reg("mid_r1", 3'd1, 8'h00);
    check_reg("mid_r2", 3'd2, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
